mcb_port_responder: RTL
=======================

Name: mcb_port_responder

Overview:
- Target-side model of one MCB user port: cmd, write-data and read-data FIFOs, backed by an on-chip word RAM.
- Accepts the same cmd/wr/rd signalling that dma drives into the memory controller.
- Lets dma and the pipe FIFO path run against a deterministic memory in simulation and in DDR2-less FPGA builds.
- Single clock domain, drop-in for c3_p0 connections.

Parameters:
- DATA_WIDTH, 32, data port width in bits.
- MASK_WIDTH, 4, byte-mask width; equals DATA_WIDTH/8.
- MEM_AW, 10, log2 of RAM depth in words; 1024 words.
- DATA_FIFO_DEPTH, 64, wr and rd FIFO depth in words.
- CMD_FIFO_DEPTH, 4, command FIFO depth.
- CALIB_CYCLES, 16, clk cycles from reset release to calib_done.

Ports:
- clk  in  1  port clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- calib_done  out  1  port usable.
- cmd_en  in  1  push command.
- cmd_instr  in  3  000 write, 001 read, 010 write+AP, 011 read+AP, others no-op.
- cmd_bl  in  6  burst length minus 1.
- cmd_byte_addr  in  30  byte address.
- cmd_empty  out  1  command FIFO empty.
- cmd_full  out  1  command FIFO full, or not calibrated.
- wr_en  in  1  push write word.
- wr_mask  in  MASK_WIDTH  1 = byte not written.
- wr_data  in  DATA_WIDTH  write word.
- wr_full  out  1  write FIFO full.
- wr_empty  out  1  write FIFO empty.
- wr_count  out  7  write FIFO occupancy, 0..64.
- wr_underrun  out  1  sticky: write burst found the write FIFO empty.
- wr_error  out  1  sticky: underrun, or push while full.
- rd_en  in  1  pop read word.
- rd_data  out  DATA_WIDTH  head of read FIFO, first-word-fall-through.
- rd_full  out  1  read FIFO full.
- rd_empty  out  1  read FIFO empty.
- rd_count  out  7  read FIFO occupancy.
- rd_overflow  out  1  sticky: read word dropped because the FIFO was full.
- rd_error  out  1  sticky: overflow, or pop while empty.

Behaviour:
- Reset state:
  - All FIFOs empty; FSM in IDLE.
  - calib_done=0, cmd_empty=1, cmd_full=1, wr_empty=1, rd_empty=1, wr_full=0, rd_full=0.
  - wr_count=0, rd_count=0; all sticky flags 0; rd_data=0.
  - RAM contents are not reset and persist across rst_n.
- Calibration:
  - 5-bit counter runs from rst_n release.
  - calib_done=1 after exactly CALIB_CYCLES rising edges.
  - Until then cmd_full=1 and cmd_en is ignored.
- Command push:
  - cmd_en with cmd_full=0 pushes {instr, bl, addr}.
  - cmd_en with cmd_full=1 is dropped; no flag is set.
- Word address = cmd_byte_addr[MEM_AW+1:2]; bits [1:0] are ignored. Burst addresses wrap modulo 2^MEM_AW.
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - If the cmd FIFO is non-empty, pop it.
  - Load addr and remaining count (bl+1).
  - Go to WRITE (instr 000/010), READ (001/011), or stay in IDLE (no-op; command consumed).
- WRITE, one word per cycle:
  - If the write FIFO is non-empty: pop it and write the RAM at addr, honouring the mask per byte.
  - If it is empty: RAM unchanged, wr_underrun=1, wr_error=1.
  - Either way addr++ and remaining--; at remaining=0 go to IDLE.
- READ, one RAM read issued per cycle:
  - Addr++ and remaining--; at remaining=0 go to DRAIN.
  - RAM latency is 1 cycle; each returned word is pushed into the read FIFO the following cycle.
  - If the read FIFO is full when a word returns: the word is dropped and rd_overflow=1, rd_error=1.
- DRAIN: one cycle for the last RAM return, then IDLE.
- Latency:
  - cmd_en accepted at edge N → command popped at N+1.
  - First write commits at N+2.
  - For a read, rd_empty falls after edge N+3.
- A new command starts no earlier than the cycle after the previous burst ends.
- Data FIFOs:
  - Simultaneous push and pop leaves the count unchanged.
  - wr_en while wr_full: word dropped, wr_error=1.
  - rd_en while rd_empty: no pop, rd_error=1.
  - rd_data updates after a pop to the next head; it holds its last value when empty.
- Write data is not bound to commands: words pushed before or after the command are equally valid.
- Reset mid-burst: the burst is aborted immediately; RAM words already committed stay.

Test Plan:
- Reset check → calib_done=0 for 16 edges, then 1; cmd_full=1 before and 0 after; all sticky flags 0.
- Write then read → push 4 words 0x11111111..0x44444444; write cmd bl=3 addr 0x100; then read cmd bl=3 addr 0x100 → rd_count reaches 4 and rd_data pops the 4 words in order.
- Byte mask → write 0xAABBCCDD with mask 0000, then 0x11223344 with mask 0101 to the same addr; read → 0x11BB33DD.
- Address wrap → write bl=1 at byte addr 0xFFC (word 1023) → the second word lands at word 0; a read bl=1 at 0x000 returns it.
- Underrun → write cmd bl=7 with 5 words queued → 5 words written, words 6-8 unchanged, wr_underrun=1 and wr_error=1 until rst_n.
- Overflow → two read cmds bl=63 with no rd_en → rd_count=64, rd_full=1, rd_overflow=1, rd_error=1; after 64 pops, data equals the first burst.

Source files
------------

// File: rtl/mcb_port_responder_if.sv
// MCB user-port bundle: cmd, write-data and read-data channels between a dma-style master and the port.
// Pure wiring: no latency; backpressure is signalled by the full/empty flags.
interface mcb_port_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
);
    logic                  calib_done;
    logic                  cmd_en;
    logic [2:0]            cmd_instr;
    logic [5:0]            cmd_bl;
    logic [29:0]           cmd_byte_addr;
    logic                  cmd_empty;
    logic                  cmd_full;
    logic                  wr_en;
    logic [MASK_WIDTH-1:0] wr_mask;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_full;
    logic                  wr_empty;
    logic [6:0]            wr_count;
    logic                  wr_underrun;
    logic                  wr_error;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_full;
    logic                  rd_empty;
    logic [6:0]            rd_count;
    logic                  rd_overflow;
    logic                  rd_error;

    modport master (
        input  calib_done, cmd_empty, cmd_full,
        input  wr_full, wr_empty, wr_count, wr_underrun, wr_error,
        input  rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error,
        output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
        output wr_en, wr_mask, wr_data, rd_en
    );

    modport slave (
        output calib_done, cmd_empty, cmd_full,
        output wr_full, wr_empty, wr_count, wr_underrun, wr_error,
        output rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error,
        input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
        input  wr_en, wr_mask, wr_data, rd_en
    );
endinterface

// File: rtl/mcb_port_responder.sv
// MCB user-port target backed by a word RAM; cmd pop 1 cycle after push, first write 2, first read word 3.
// Full FIFOs drop pushes, empty FIFOs ignore pops; both cases raise sticky error flags.
module mcb_port_responder_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic [AW:0]  count_o,
    output logic         full_o,
    output logic         empty_o
);
    logic [W-1:0]  mem_q [2**AW];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = cnt_q[AW];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end
endmodule

module mcb_port_responder #(
    parameter int DATA_WIDTH      = 32,
    parameter int MASK_WIDTH      = 4,
    parameter int MEM_AW          = 10,
    parameter int DATA_FIFO_DEPTH = 64,
    parameter int CMD_FIFO_DEPTH  = 4,
    parameter int CALIB_CYCLES    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mcb_port_responder_if.slave  p
);
    localparam int DAW = $clog2(DATA_FIFO_DEPTH);
    localparam int CAW = $clog2(CMD_FIFO_DEPTH);

    typedef struct packed {
        logic [2:0]        instr;
        logic [5:0]        bl;
        logic [MEM_AW-1:0] waddr;
    } cmd_t;

    typedef struct packed {
        logic [MASK_WIDTH-1:0] mask;
        logic [DATA_WIDTH-1:0] data;
    } wr_t;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [MEM_AW-1:0]     addr_q, addr_d;
    logic [6:0]            rem_q, rem_d;
    logic [4:0]            cal_cnt_q;
    logic                  calib_done;
    logic                  cmd_pop, wr_pop, ram_we, ram_re, underrun;
    logic                  rvld_q;
    logic [DATA_WIDTH-1:0] rdata_q, rd_hold_q, rd_head, rd_data_w;
    logic                  wr_underrun_q, wr_error_q, rd_overflow_q, rd_error_q;
    logic                  cmd_fifo_full, cmd_fifo_empty;
    logic [CAW:0]          cmd_cnt_unused;
    cmd_t                  cmd_in, cmd_head;
    wr_t                   wr_head;
    logic [DATA_WIDTH-1:0] mem [2**MEM_AW];
    logic                  unused_addr_bits;

    assign calib_done       = (cal_cnt_q == 5'(CALIB_CYCLES));
    assign cmd_in           = '{instr: p.cmd_instr, bl: p.cmd_bl, waddr: p.cmd_byte_addr[MEM_AW+1:2]};
    assign unused_addr_bits = ^{p.cmd_byte_addr[29:MEM_AW+2], p.cmd_byte_addr[1:0]};

    mcb_port_responder_fifo #(.W($bits(cmd_t)), .AW(CAW)) u_cmd_fifo (
        .clk(clk), .rst_n(rst_n),
        .push_i(p.cmd_en && !p.cmd_full), .data_i(cmd_in), .pop_i(cmd_pop),
        .data_o(cmd_head), .count_o(cmd_cnt_unused), .full_o(cmd_fifo_full), .empty_o(cmd_fifo_empty)
    );

    mcb_port_responder_fifo #(.W($bits(wr_t)), .AW(DAW)) u_wr_fifo (
        .clk(clk), .rst_n(rst_n),
        .push_i(p.wr_en), .data_i({p.wr_mask, p.wr_data}), .pop_i(wr_pop),
        .data_o(wr_head), .count_o(p.wr_count), .full_o(p.wr_full), .empty_o(p.wr_empty)
    );

    mcb_port_responder_fifo #(.W(DATA_WIDTH), .AW(DAW)) u_rd_fifo (
        .clk(clk), .rst_n(rst_n),
        .push_i(rvld_q), .data_i(rdata_q), .pop_i(p.rd_en),
        .data_o(rd_head), .count_o(p.rd_count), .full_o(p.rd_full), .empty_o(p.rd_empty)
    );

    // Hold the last head so rd_data stays stable once the read FIFO runs dry.
    assign rd_data_w     = p.rd_empty ? rd_hold_q : rd_head;
    assign p.rd_data     = rd_data_w;
    assign p.calib_done  = calib_done;
    assign p.cmd_full    = cmd_fifo_full || !calib_done;
    assign p.cmd_empty   = cmd_fifo_empty;
    assign p.wr_underrun = wr_underrun_q;
    assign p.wr_error    = wr_error_q;
    assign p.rd_overflow = rd_overflow_q;
    assign p.rd_error    = rd_error_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        cmd_pop  = 1'b0;
        wr_pop   = 1'b0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        underrun = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cmd_fifo_empty) begin
                    cmd_pop = 1'b1;
                    addr_d  = cmd_head.waddr;
                    rem_d   = {1'b0, cmd_head.bl} + 7'd1;
                    if (!cmd_head.instr[2]) state_d = cmd_head.instr[0] ? READ : WRITE;
                end
            end
            WRITE: begin
                wr_pop   = !p.wr_empty;
                ram_we   = !p.wr_empty;
                underrun = p.wr_empty;
                addr_d   = addr_q + 1'b1;
                rem_d    = rem_q - 7'd1;
                if (rem_q == 7'd1) state_d = IDLE;
            end
            READ: begin
                ram_re = 1'b1;
                addr_d = addr_q + 1'b1;
                rem_d  = rem_q - 7'd1;
                if (rem_q == 7'd1) state_d = DRAIN;
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            rem_q         <= '0;
            cal_cnt_q     <= '0;
            rvld_q        <= 1'b0;
            rd_hold_q     <= '0;
            wr_underrun_q <= 1'b0;
            wr_error_q    <= 1'b0;
            rd_overflow_q <= 1'b0;
            rd_error_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            if (!calib_done) cal_cnt_q <= cal_cnt_q + 5'd1;
            rvld_q        <= ram_re;
            rd_hold_q     <= rd_data_w;
            wr_underrun_q <= wr_underrun_q | underrun;
            wr_error_q    <= wr_error_q | underrun | (p.wr_en & p.wr_full);
            rd_overflow_q <= rd_overflow_q | (rvld_q & p.rd_full);
            rd_error_q    <= rd_error_q | (rvld_q & p.rd_full) | (p.rd_en & p.rd_empty);
        end
    end

    // RAM is deliberately outside reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (!wr_head.mask[b]) mem[addr_q][b*8 +: 8] <= wr_head.data[b*8 +: 8];
            end
        end
        if (ram_re) rdata_q <= mem[addr_q];
    end
endmodule
